wbm2axilite: RTL and testbench
==============================

Name: wbm2axilite

Overview:
- Wishbone (pipelined, B4) slave to AXI4-Lite master bridge; the inverse of the AXI-Lite-to-Wishbone slave bridge used in front of the peripherals.
- Lets a Wishbone-side master (CPU data bus, DMA) reach AXI-Lite peripherals such as the interrupt controller.
- Only one transaction is in flight at a time; the block stays stalled until the AXI response returns.
- Includes a response timeout and abort handling for when Wishbone CYC drops.

Parameters:
- C_AXI_DATA_WIDTH, 32, AXI/WB data width (32 or 64).
- C_AXI_ADDR_WIDTH, 28, AXI byte address width.
- AXILLSB, $clog2(C_AXI_DATA_WIDTH/8), localparam; WB word-address to byte-address shift.
- LGTIMEOUT, 8, response timeout is 2^LGTIMEOUT cycles; 0 disables the timeout.
- OPT_READONLY, 1'b0, when 1 every write is refused with err and no AXI write is issued.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_wb_cyc, i_wb_stb, i_wb_we  in  1  Wishbone cycle, strobe, write enable
- i_wb_addr  in  C_AXI_ADDR_WIDTH-AXILLSB  Wishbone word address
- i_wb_data  in  C_AXI_DATA_WIDTH  Wishbone write data
- i_wb_sel  in  C_AXI_DATA_WIDTH/8  Wishbone byte selects
- o_wb_stall, o_wb_ack, o_wb_err  out  1  Wishbone stall, acknowledge, error
- o_wb_data  out  C_AXI_DATA_WIDTH  Wishbone read data
- o_axi_awvalid out 1 / i_axi_awready in 1 / o_axi_awaddr out C_AXI_ADDR_WIDTH / o_axi_awprot out 3: AXI write address channel
- o_axi_wvalid out 1 / i_axi_wready in 1 / o_axi_wdata out C_AXI_DATA_WIDTH / o_axi_wstrb out C_AXI_DATA_WIDTH/8: AXI write data channel
- i_axi_bvalid in 1 / o_axi_bready out 1 / i_axi_bresp in 2: AXI write response channel
- o_axi_arvalid out 1 / i_axi_arready in 1 / o_axi_araddr out C_AXI_ADDR_WIDTH / o_axi_arprot out 3: AXI read address channel
- i_axi_rvalid in 1 / o_axi_rready out 1 / i_axi_rdata in C_AXI_DATA_WIDTH / i_axi_rresp in 2: AXI read data channel

Behaviour:
- Reset (async): state IDLE; every valid and ready output, o_wb_ack, o_wb_err and o_wb_stall are 0; addr/data/strb/o_wb_data are 0; the timeout counter and the abort flag are cleared.
- awprot and arprot are constant 3'b000.
- States: IDLE, WRITE, READ, RESP. o_wb_stall = (state != IDLE).
- IDLE, on i_wb_cyc & i_wb_stb:
  - Latch address {i_wb_addr, AXILLSB'b0}, plus i_wb_data and i_wb_sel.
  - If we=1 and OPT_READONLY=0: next cycle awvalid=wvalid=bready=1, go to WRITE.
  - If we=0: next cycle arvalid=rready=1, go to READ.
  - If we=1 and OPT_READONLY=1: o_wb_err=1 for one cycle next cycle, stay IDLE, no AXI activity.
- WRITE:
  - awvalid and wvalid each drop independently on their own handshake.
  - bready stays high until the B handshake. A B handshake is accepted even before AW/W complete.
  - Exit to RESP only when AW done, W done and B handshaken.
- READ: arvalid drops on the AR handshake. On the R handshake, i_axi_rdata is registered into o_wb_data; go to RESP.
- RESP (one cycle):
  - o_wb_ack=1 if resp[1]==0 (OKAY/EXOKAY); o_wb_err=1 if resp[1]==1 (SLVERR/DECERR).
  - Both are suppressed if the abort flag or the timeout-fired flag is set.
  - Return to IDLE; ack and err are single-cycle pulses.
- Minimum latency: stb accepted at cycle N, AXI valid at N+1; with a zero-wait slave the response arrives at N+2 and ack/err at N+3.
- Abort: i_wb_cyc low while in WRITE/READ sets the abort flag. AXI handshakes still complete (outstanding valids are never withdrawn), no ack/err is produced, and the flag clears on return to IDLE.
- Timeout (LGTIMEOUT>0):
  - The counter runs in WRITE/READ and resets on entry to either state.
  - At terminal count: o_wb_err pulses once and the timeout-fired flag is set.
  - The block stays in WRITE/READ, stalled, until AXI completes, then returns to IDLE silently.
- Simultaneous events:
  - Abort and timeout in the same cycle: abort wins, no err.
  - Response arriving in the same cycle as the terminal count: the response wins, the timeout does not fire.
- o_wb_data holds its last read value until the next read completes.
- Reset mid-transaction clears all state immediately. The AXI slave is required to share the reset.

Decomposition:
- Shared package wb_axil_pkg:
  - state enum {IDLE, WRITE, READ, RESP}
  - AXI response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - PROT_DEFAULT=3'b000
- One sub-module: wbm2axilite_timeout (loadable down-counter with terminal-count pulse), reused by other bus bridges.

Test Plan:
- Read: WB read of addr 0x0000010 with the slave answering rdata=0xDEADBEEF, OKAY, zero wait -> araddr=0x0000040, ack at N+3, o_wb_data=0xDEADBEEF, stall high for cycles N+1..N+3.
- Write: WB write of data 0x12345678, sel 4'b0011; slave holds awready low 3 cycles while wready is immediate -> wvalid drops first, awvalid drops after 3 cycles, wstrb=4'b0011, exactly one ack.
- Error response: slave returns bresp=2'b10 -> o_wb_err pulses one cycle, no ack. Repeat with rresp=2'b11 -> err.
- Abort: drop cyc 1 cycle after issuing a read, slave responds 5 cycles later -> no ack/err, stall released after R handshake, next transaction succeeds normally.
- Timeout: LGTIMEOUT=4, slave withholds bvalid for 40 cycles -> err at cycle 16 of WRITE, stall held until B handshake, no second err/ack.
- OPT_READONLY=1: any write -> err at N+1, all AXI valids stay 0; a following read completes with ack.

Source files
------------

// File: rtl/wb_axil_pkg.sv
// Shared definitions for the Wishbone <-> AXI-Lite bridges: FSM states,
// AXI response codes and the fixed protection value.
package wb_axil_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // SLVERR and DECERR both map to a Wishbone error
  function automatic logic resp_is_err(input logic [1:0] r);
    return r[1];
  endfunction
endpackage

// File: rtl/wbm2axilite_if.sv
// Bus bundle for the bridge: pipelined Wishbone slave side plus the five AXI-Lite
// master channels. Modport slave is the bridge view, master is the outside world.
interface wbm2axilite_if #(
  parameter int DW = 32,
  parameter int AW = 28
);
  localparam int LSB = $clog2(DW/8);

  logic                i_wb_cyc, i_wb_stb, i_wb_we;
  logic [AW-LSB-1:0]   i_wb_addr;
  logic [DW-1:0]       i_wb_data;
  logic [DW/8-1:0]     i_wb_sel;
  logic                o_wb_stall, o_wb_ack, o_wb_err;
  logic [DW-1:0]       o_wb_data;

  logic                o_axi_awvalid, i_axi_awready;
  logic [AW-1:0]       o_axi_awaddr;
  logic [2:0]          o_axi_awprot;
  logic                o_axi_wvalid, i_axi_wready;
  logic [DW-1:0]       o_axi_wdata;
  logic [DW/8-1:0]     o_axi_wstrb;
  logic                i_axi_bvalid, o_axi_bready;
  logic [1:0]          i_axi_bresp;
  logic                o_axi_arvalid, i_axi_arready;
  logic [AW-1:0]       o_axi_araddr;
  logic [2:0]          o_axi_arprot;
  logic                i_axi_rvalid, o_axi_rready;
  logic [DW-1:0]       i_axi_rdata;
  logic [1:0]          i_axi_rresp;

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
    output o_axi_awvalid, o_axi_awaddr, o_axi_awprot, input i_axi_awready,
    output o_axi_wvalid, o_axi_wdata, o_axi_wstrb, input i_axi_wready,
    input  i_axi_bvalid, i_axi_bresp, output o_axi_bready,
    output o_axi_arvalid, o_axi_araddr, o_axi_arprot, input i_axi_arready,
    input  i_axi_rvalid, i_axi_rdata, i_axi_rresp, output o_axi_rready
  );

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_err, o_wb_data,
    input  o_axi_awvalid, o_axi_awaddr, o_axi_awprot, output i_axi_awready,
    input  o_axi_wvalid, o_axi_wdata, o_axi_wstrb, output i_axi_wready,
    output i_axi_bvalid, i_axi_bresp, input o_axi_bready,
    input  o_axi_arvalid, o_axi_araddr, o_axi_arprot, output i_axi_arready,
    output i_axi_rvalid, i_axi_rdata, i_axi_rresp, input o_axi_rready
  );
endinterface

// File: rtl/wbm2axilite_timeout.sv
// Loadable down-counter; o_tc pulses once when the count reaches zero while
// enabled, and re-arms only on the next load.
module wbm2axilite_timeout #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);
  logic [W-1:0] cnt;
  logic         armed;

  assign o_tc = i_en & armed & (cnt == '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (i_load) begin
      cnt   <= i_load_val;
      armed <= 1'b1;
    end else if (i_en) begin
      if (cnt != '0) cnt   <= cnt - 1'b1;
      else           armed <= 1'b0;
    end
  end
endmodule

// File: rtl/wbm2axilite.sv
// Pipelined Wishbone slave to AXI4-Lite master bridge, one transaction in flight,
// with response timeout and silent completion when the Wishbone cycle is abandoned.
module wbm2axilite
  import wb_axil_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 28,
  parameter int LGTIMEOUT        = 8,
  parameter bit OPT_READONLY     = 1'b0
) (
  input logic          i_clk,
  input logic          i_reset,
  wbm2axilite_if.slave bus
);
  localparam int DW      = C_AXI_DATA_WIDTH;
  localparam int AW      = C_AXI_ADDR_WIDTH;
  localparam int AXILLSB = $clog2(DW/8);

  state_t          state, state_n;
  logic            awv_q, awv_n, wv_q, wv_n, bready_q, bready_n;
  logic            arv_q, arv_n, rready_q, rready_n;
  logic            ack_q, ack_n, err_q, err_n;
  logic            abort_q, abort_n, fired_q, fired_n;
  logic            b_done_q, b_done_n;
  logic [1:0]      b_resp_q, b_resp_n, wr_resp;
  logic [AW-1:0]   addr_q, addr_n;
  logic [DW-1:0]   wdata_q, wdata_n, rdata_q, rdata_n;
  logic [DW/8-1:0] wstrb_q, wstrb_n;
  logic            b_hs, r_hs, aw_fin, w_fin, b_fin, quiet;
  logic            tmr_load, tmr_en, tmr_tc;

  assign bus.o_wb_stall    = (state != IDLE);
  assign bus.o_wb_ack      = ack_q;
  assign bus.o_wb_err      = err_q;
  assign bus.o_wb_data     = rdata_q;
  assign bus.o_axi_awvalid = awv_q;
  assign bus.o_axi_awaddr  = addr_q;
  assign bus.o_axi_awprot  = PROT_DEFAULT;
  assign bus.o_axi_wvalid  = wv_q;
  assign bus.o_axi_wdata   = wdata_q;
  assign bus.o_axi_wstrb   = wstrb_q;
  assign bus.o_axi_bready  = bready_q;
  assign bus.o_axi_arvalid = arv_q;
  assign bus.o_axi_araddr  = addr_q;
  assign bus.o_axi_arprot  = PROT_DEFAULT;
  assign bus.o_axi_rready  = rready_q;

  assign b_hs    = bready_q & bus.i_axi_bvalid;
  assign r_hs    = rready_q & bus.i_axi_rvalid;
  assign aw_fin  = ~awv_q | bus.i_axi_awready;
  assign w_fin   = ~wv_q  | bus.i_axi_wready;
  assign b_fin   = b_done_q | b_hs;
  // B may have been accepted earlier while AW/W were still pending
  assign wr_resp = b_done_q ? b_resp_q : bus.i_axi_bresp;
  // No Wishbone reply once the master has walked away or the timeout already spoke
  assign quiet   = ~abort_q & bus.i_wb_cyc & ~fired_q;
  assign tmr_en  = (state == WRITE) || (state == READ);

  generate
    if (LGTIMEOUT > 0) begin : g_tmo
      wbm2axilite_timeout #(.W(LGTIMEOUT)) u_tmo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (tmr_load),
        .i_en       (tmr_en),
        .i_load_val (LGTIMEOUT'(2**LGTIMEOUT - 2)),
        .o_tc       (tmr_tc)
      );
    end else begin : g_no_tmo
      logic unused_tmo;
      assign unused_tmo = tmr_load ^ tmr_en;
      assign tmr_tc     = 1'b0;
    end
  endgenerate

  always_comb begin
    state_n  = state;
    awv_n    = awv_q & ~bus.i_axi_awready;
    wv_n     = wv_q & ~bus.i_axi_wready;
    bready_n = bready_q & ~bus.i_axi_bvalid;
    arv_n    = arv_q & ~bus.i_axi_arready;
    rready_n = rready_q & ~bus.i_axi_rvalid;
    b_done_n = b_done_q | b_hs;
    b_resp_n = b_hs ? bus.i_axi_bresp : b_resp_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    wstrb_n  = wstrb_q;
    rdata_n  = r_hs ? bus.i_axi_rdata : rdata_q;
    ack_n    = 1'b0;
    err_n    = 1'b0;
    abort_n  = abort_q;
    fired_n  = fired_q;
    tmr_load = 1'b0;
    case (state)
      IDLE: begin
        abort_n  = 1'b0;
        fired_n  = 1'b0;
        b_done_n = 1'b0;
        if (bus.i_wb_cyc && bus.i_wb_stb) begin
          addr_n  = {bus.i_wb_addr, {AXILLSB{1'b0}}};
          wdata_n = bus.i_wb_data;
          wstrb_n = bus.i_wb_sel;
          if (!bus.i_wb_we) begin
            arv_n    = 1'b1;
            rready_n = 1'b1;
            state_n  = READ;
            tmr_load = 1'b1;
          end else if (OPT_READONLY) begin
            err_n = 1'b1;
          end else begin
            awv_n    = 1'b1;
            wv_n     = 1'b1;
            bready_n = 1'b1;
            state_n  = WRITE;
            tmr_load = 1'b1;
          end
        end
      end
      WRITE: begin
        if (!bus.i_wb_cyc) abort_n = 1'b1;
        if (aw_fin && w_fin && b_fin) begin
          state_n = RESP;
          ack_n   = quiet & ~resp_is_err(wr_resp);
          err_n   = quiet & resp_is_err(wr_resp);
        end else if (tmr_tc && quiet) begin
          err_n   = 1'b1;
          fired_n = 1'b1;
        end
      end
      READ: begin
        if (!bus.i_wb_cyc) abort_n = 1'b1;
        if (r_hs) begin
          state_n = RESP;
          ack_n   = quiet & ~resp_is_err(bus.i_axi_rresp);
          err_n   = quiet & resp_is_err(bus.i_axi_rresp);
        end else if (tmr_tc && quiet) begin
          err_n   = 1'b1;
          fired_n = 1'b1;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      awv_q    <= 1'b0;
      wv_q     <= 1'b0;
      bready_q <= 1'b0;
      arv_q    <= 1'b0;
      rready_q <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      fired_q  <= 1'b0;
      b_done_q <= 1'b0;
      b_resp_q <= RESP_OKAY;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state    <= state_n;
      awv_q    <= awv_n;
      wv_q     <= wv_n;
      bready_q <= bready_n;
      arv_q    <= arv_n;
      rready_q <= rready_n;
      ack_q    <= ack_n;
      err_q    <= err_n;
      abort_q  <= abort_n;
      fired_q  <= fired_n;
      b_done_q <= b_done_n;
      b_resp_q <= b_resp_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
      wstrb_q  <= wstrb_n;
      rdata_q  <= rdata_n;
    end
  end
endmodule

// File: tb/tb_wbm2axilite.sv
// Bench for wbm2axilite: cycle-stepped AXI slave with programmable delays, a
// word-memory reference model, directed corner cases and a randomized mix.
module tb_wbm2axilite;
  import wb_axil_pkg::*;
  localparam int DW = 32, AW = 28;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  wbm2axilite_if #(.DW(DW), .AW(AW)) b1 ();
  wbm2axilite_if #(.DW(DW), .AW(AW)) b2 ();

  wbm2axilite #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .LGTIMEOUT(4), .OPT_READONLY(1'b0))
    dut (.i_clk(clk), .i_reset(rst), .bus(b1));
  wbm2axilite #(.C_AXI_DATA_WIDTH(DW), .C_AXI_ADDR_WIDTH(AW), .LGTIMEOUT(8), .OPT_READONLY(1'b1))
    dut_ro (.i_clk(clk), .i_reset(rst), .bus(b2));

  // shared stimulus; Wishbone strobes steered to the selected bridge
  logic use_ro = 1'b0;
  logic cyc = 0, stb = 0, we = 0;
  logic [AW-3:0] addr = '0;
  logic [31:0] data = '0, rdata = '0;
  logic [3:0] sel = '0;
  logic awready = 0, wready = 0, bvalid = 0, arready = 0, rvalid = 0;
  logic [1:0] bresp = '0, rresp = '0;

  assign b1.i_wb_cyc = cyc & ~use_ro;  assign b2.i_wb_cyc = cyc & use_ro;
  assign b1.i_wb_stb = stb & ~use_ro;  assign b2.i_wb_stb = stb & use_ro;
  assign b1.i_wb_we = we;       assign b2.i_wb_we = we;
  assign b1.i_wb_addr = addr;   assign b2.i_wb_addr = addr;
  assign b1.i_wb_data = data;   assign b2.i_wb_data = data;
  assign b1.i_wb_sel = sel;     assign b2.i_wb_sel = sel;
  assign b1.i_axi_awready = awready; assign b2.i_axi_awready = awready;
  assign b1.i_axi_wready = wready;   assign b2.i_axi_wready = wready;
  assign b1.i_axi_bvalid = bvalid;   assign b2.i_axi_bvalid = bvalid;
  assign b1.i_axi_bresp = bresp;     assign b2.i_axi_bresp = bresp;
  assign b1.i_axi_arready = arready; assign b2.i_axi_arready = arready;
  assign b1.i_axi_rvalid = rvalid;   assign b2.i_axi_rvalid = rvalid;
  assign b1.i_axi_rdata = rdata;     assign b2.i_axi_rdata = rdata;
  assign b1.i_axi_rresp = rresp;     assign b2.i_axi_rresp = rresp;

  logic stall, ack, err, awv, wv, bready, arv, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [31:0] wdata, rdo;
  logic [3:0] wstrb;
  logic [2:0] awprot, arprot;
  assign stall  = use_ro ? b2.o_wb_stall    : b1.o_wb_stall;
  assign ack    = use_ro ? b2.o_wb_ack      : b1.o_wb_ack;
  assign err    = use_ro ? b2.o_wb_err      : b1.o_wb_err;
  assign rdo    = use_ro ? b2.o_wb_data     : b1.o_wb_data;
  assign awv    = use_ro ? b2.o_axi_awvalid : b1.o_axi_awvalid;
  assign awaddr = use_ro ? b2.o_axi_awaddr  : b1.o_axi_awaddr;
  assign awprot = use_ro ? b2.o_axi_awprot  : b1.o_axi_awprot;
  assign wv     = use_ro ? b2.o_axi_wvalid  : b1.o_axi_wvalid;
  assign wdata  = use_ro ? b2.o_axi_wdata   : b1.o_axi_wdata;
  assign wstrb  = use_ro ? b2.o_axi_wstrb   : b1.o_axi_wstrb;
  assign bready = use_ro ? b2.o_axi_bready  : b1.o_axi_bready;
  assign arv    = use_ro ? b2.o_axi_arvalid : b1.o_axi_arvalid;
  assign araddr = use_ro ? b2.o_axi_araddr  : b1.o_axi_araddr;
  assign arprot = use_ro ? b2.o_axi_arprot  : b1.o_axi_arprot;
  assign rready = use_ro ? b2.o_axi_rready  : b1.o_axi_rready;

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [31:0] slv_mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] last_rd = '0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // observations of the most recent transaction (t counts cycles after the stb cycle)
  int n_ack, n_err, t_ack, t_err, t_awdrop, t_wdrop, t_idle, any_valid, stall1;
  logic [AW-1:0] cap_awaddr, cap_araddr;
  logic [31:0] cap_wdata, rd_at_ack;
  logic [3:0] cap_wstrb;

  task automatic xact(input bit w, input logic [AW-3:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_d, input int w_d, input int ar_d, input int rsp_d,
                      input logic [1:0] rsp, input int abort_t);
    int aw_t, w_t, ar_t, b_t, r_t;
    bit bdone, rdone;
    aw_t = -1; w_t = -1; ar_t = -1; b_t = -1; r_t = -1; bdone = 0; rdone = 0;
    n_ack = 0; n_err = 0; t_ack = -1; t_err = -1; t_awdrop = -1; t_wdrop = -1;
    t_idle = -1; any_valid = 0; stall1 = 0;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; addr = a; data = d; sel = s;
    for (int t = 1; t <= 200; t++) begin
      @(negedge clk);
      stb = 0;
      if (abort_t > 0 && t >= abort_t) cyc = 0;
      if (t == 1) stall1 = int'(stall);
      if (ack) begin n_ack++; if (t_ack < 0) begin t_ack = t; rd_at_ack = rdo; end end
      if (err) begin n_err++; if (t_err < 0) t_err = t; end
      if (awv | wv | arv) any_valid = 1;
      if (!awv && t_awdrop < 0) t_awdrop = t;
      if (!wv && t_wdrop < 0) t_wdrop = t;
      if (!stall && t_idle < 0) t_idle = t;
      if (t_idle >= 0 && t >= t_idle + 3) break;
      awready = (t >= 1 + aw_d);
      wready  = (t >= 1 + w_d);
      arready = (t >= 1 + ar_d);
      if (awv && awready && aw_t < 0) begin aw_t = t; cap_awaddr = awaddr; end
      if (wv && wready && w_t < 0) begin w_t = t; cap_wdata = wdata; cap_wstrb = wstrb; end
      if (aw_t >= 0 && w_t >= 0 && b_t < 0) b_t = ((aw_t > w_t) ? aw_t : w_t) + 1 + rsp_d;
      bvalid = (b_t >= 0 && t >= b_t && !bdone);
      bresp  = bvalid ? rsp : RESP_OKAY;
      if (bvalid && bready) begin
        bdone = 1;
        slv_mem[cap_awaddr[9:2]] = merge(slv_mem[cap_awaddr[9:2]], cap_wdata, cap_wstrb);
      end
      if (arv && arready && ar_t < 0) begin ar_t = t; cap_araddr = araddr; end
      if (ar_t >= 0 && r_t < 0) r_t = ar_t + 1 + rsp_d;
      rvalid = (r_t >= 0 && t >= r_t && !rdone);
      rresp  = rvalid ? rsp : RESP_OKAY;
      rdata  = rvalid ? slv_mem[cap_araddr[9:2]] : '0;
      if (rvalid && rready) rdone = 1;
    end
    cyc = 0; stb = 0; awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    if (t_idle < 0) chk("cycle_bound", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit w; logic [AW-3:0] a; logic [31:0] d; logic [3:0] s; logic [1:0] rsp;
    int awd, wd, ard, rd_d, exp_t;
    for (int i = 0; i < 256; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end

    repeat (2) @(negedge clk);
    chk("rst_wb", {stall, ack, err}, 3'b000);
    chk("rst_valid", {awv, wv, bready, arv, rready}, 5'b0);
    chk("rst_data", {awaddr, wdata, wstrb, rdo}, '0);
    rst = 0;
    @(negedge clk);
    chk("prot", {awprot, arprot}, {PROT_DEFAULT, PROT_DEFAULT});

    // zero-wait read
    slv_mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    xact(0, 'h10, '0, '0, 0, 0, 0, 0, RESP_OKAY, 0);
    last_rd = ref_mem[16];
    chk("rd_araddr", cap_araddr, 'h40);
    chk("rd_ack_t", t_ack, 3);
    chk("rd_acks", {n_ack, n_err}, {32'd1, 32'd0});
    chk("rd_data", rd_at_ack, 32'hDEADBEEF);
    chk("rd_stall", {stall1, t_idle}, {32'd1, 32'd4});

    // write with AW held off for 3 cycles, W immediate
    xact(1, 'h5, 32'h12345678, 4'b0011, 3, 0, 0, 0, RESP_OKAY, 0);
    ref_mem[5] = merge(ref_mem[5], 32'h12345678, 4'b0011);
    chk("wr_wdrop", t_wdrop, 2);
    chk("wr_awdrop", t_awdrop, 5);
    chk("wr_beat", {cap_awaddr, cap_wdata, cap_wstrb}, {28'h14, 32'h12345678, 4'b0011});
    chk("wr_acks", {n_ack, n_err, t_ack}, {32'd1, 32'd0, 32'd6});
    chk("wr_hold_rdata", rdo, last_rd);

    // error responses
    xact(1, 'h5, 32'hA5A5A5A5, 4'b1100, 0, 0, 0, 0, RESP_SLVERR, 0);
    ref_mem[5] = merge(ref_mem[5], 32'hA5A5A5A5, 4'b1100);
    chk("bresp_err", {n_ack, n_err, t_err}, {32'd0, 32'd1, 32'd3});
    xact(0, 'h5, '0, '0, 0, 0, 0, 0, RESP_DECERR, 0);
    last_rd = ref_mem[5];
    chk("rresp_err", {n_ack, n_err, t_err}, {32'd0, 32'd1, 32'd3});

    // abandoned read: slave answers late, no Wishbone reply
    xact(0, 'h10, '0, '0, 0, 0, 0, 5, RESP_OKAY, 2);
    last_rd = ref_mem[16];
    chk("abort_quiet", {n_ack, n_err}, {32'd0, 32'd0});
    chk("abort_release", t_idle, 9);
    chk("abort_rdata", rdo, last_rd);
    xact(0, 'h5, '0, '0, 0, 0, 0, 0, RESP_OKAY, 0);
    last_rd = ref_mem[5];
    chk("post_abort", {n_ack, n_err, t_ack}, {32'd1, 32'd0, 32'd3});
    chk("post_abort_data", rd_at_ack, ref_mem[5]);

    // timeout: B withheld for ~40 cycles
    xact(1, 'h6, 32'hCAFEF00D, 4'b1111, 0, 0, 0, 39, RESP_OKAY, 0);
    ref_mem[6] = 32'hCAFEF00D;
    chk("tmo_err_t", t_err, 16);
    chk("tmo_once", {n_ack, n_err}, {32'd0, 32'd1});
    chk("tmo_release", t_idle, 43);

    // read-only bridge
    use_ro = 1;
    xact(1, 'h7, 32'h11111111, 4'b1111, 0, 0, 0, 0, RESP_OKAY, 0);
    chk("ro_wr_err", {n_ack, n_err, t_err}, {32'd0, 32'd1, 32'd1});
    chk("ro_no_axi", {any_valid, t_idle}, {32'd0, 32'd1});
    xact(0, 'h5, '0, '0, 0, 0, 0, 0, RESP_OKAY, 0);
    chk("ro_rd", {n_ack, n_err, t_ack}, {32'd1, 32'd0, 32'd3});
    chk("ro_rd_data", rd_at_ack, ref_mem[5]);
    use_ro = 0;

    // randomized mix against the memory model
    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      a = AW'(0) | (AW-2)'($urandom_range(0, 7));
      d = $urandom; s = 4'($urandom_range(1, 15));
      awd = $urandom_range(0, 3); wd = $urandom_range(0, 3);
      ard = $urandom_range(0, 3); rd_d = $urandom_range(0, 3);
      rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      xact(w, a, d, s, awd, wd, ard, rd_d, rsp, 0);
      if (w) begin
        exp_t = ((awd > wd) ? awd : wd) + rd_d + 3;
        ref_mem[a[7:0]] = merge(ref_mem[a[7:0]], d, s);
        chk("rnd_wr_beat", {cap_awaddr, cap_wdata, cap_wstrb}, {{a, 2'b00}, d, s});
      end else begin
        exp_t = ard + rd_d + 3;
        last_rd = ref_mem[a[7:0]];
        chk("rnd_araddr", cap_araddr, {a, 2'b00});
        if (!rsp[1]) chk("rnd_rdata", rd_at_ack, last_rd);
      end
      chk("rnd_reply", {n_ack, n_err}, rsp[1] ? {32'd0, 32'd1} : {32'd1, 32'd0});
      chk("rnd_reply_t", rsp[1] ? t_err : t_ack, exp_t);
      chk("rnd_hold", rdo, last_rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
